// File: rtl/ascon_ctrl_fsm.sv
// Phase sequencer for the ASCON-128 encryption datapath: walks init (pa), AD (pb),
// plaintext blocks (pb) and finalization (pa), driving counter controls and datapath enables.
module ascon_ctrl_fsm #(
  parameter int NB_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic [3:0] round_i,
  input  logic [2:0] block_i,
  output logic       en_round_o,
  output logic       init_a_round_o,
  output logic       init_b_round_o,
  output logic       en_block_o,
  output logic       init_block_o,
  output logic       mux_select_o,
  output logic       en_reg_state_o,
  output logic       en_xor_data_o,
  output logic       en_xor_key_begin_o,
  output logic       en_xor_key_end_o,
  output logic       en_xor_lsb_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       cipher_valid_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT_RND = 3'd1,
    WAIT_AD  = 3'd2,
    AD_RND   = 3'd3,
    WAIT_PT  = 3'd4,
    PT_RND   = 3'd5,
    FIN_RND  = 3'd6,
    DONE     = 3'd7
  } state_t;

  // pa phases count 0..11, pb phases are loaded at 6 so every phase ends on 11
  localparam logic [3:0] FIRST_PA   = 4'd0;
  localparam logic [3:0] FIRST_PB   = 4'd6;
  localparam logic [3:0] LAST_ROUND = 4'd11;
  localparam logic [2:0] LAST_BLOCK = 3'(NB_BLOCKS - 1);

  state_t state_q, state_d;
  logic   cipher_valid_q;
  logic   last_round;
  logic   last_block;

  assign last_round     = (round_i == LAST_ROUND);
  assign last_block     = (block_i == LAST_BLOCK);
  assign cipher_valid_o = cipher_valid_q;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q        <= IDLE;
      cipher_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cipher_valid_q <= en_cipher_o;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_i) state_d = INIT_RND;
      INIT_RND:   if (last_round) state_d = WAIT_AD;
      WAIT_AD:    if (data_valid_i) state_d = AD_RND;
      AD_RND:     if (last_round) state_d = WAIT_PT;
      WAIT_PT: begin
        // the final block is absorbed by the finalization permutation itself
        if (data_valid_i) state_d = last_block ? FIN_RND : PT_RND;
      end
      PT_RND:     if (last_round) state_d = WAIT_PT;
      FIN_RND:    if (last_round) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    en_round_o         = 1'b0;
    init_a_round_o     = 1'b0;
    init_b_round_o     = 1'b0;
    en_block_o         = 1'b0;
    init_block_o       = 1'b0;
    mux_select_o       = 1'b0;
    en_reg_state_o     = 1'b0;
    en_xor_data_o      = 1'b0;
    en_xor_key_begin_o = 1'b0;
    en_xor_key_end_o   = 1'b0;
    en_xor_lsb_o       = 1'b0;
    en_cipher_o        = 1'b0;
    en_tag_o           = 1'b0;
    done_o             = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        done_o = (state_q == DONE);
        if (start_i) begin
          en_round_o     = 1'b1;
          init_a_round_o = 1'b1;
          en_block_o     = 1'b1;
          init_block_o   = 1'b1;
        end
      end
      INIT_RND: begin
        en_reg_state_o   = 1'b1;
        en_round_o       = 1'b1;
        mux_select_o     = (round_i == FIRST_PA);
        en_xor_key_end_o = last_round;
      end
      WAIT_AD: begin
        if (data_valid_i) begin
          en_round_o     = 1'b1;
          init_b_round_o = 1'b1;
        end
      end
      AD_RND: begin
        en_reg_state_o = 1'b1;
        en_round_o     = 1'b1;
        en_xor_data_o  = (round_i == FIRST_PB);
        en_xor_lsb_o   = last_round;
      end
      WAIT_PT: begin
        if (data_valid_i) begin
          en_round_o     = 1'b1;
          init_a_round_o = last_block;
          init_b_round_o = !last_block;
        end
      end
      PT_RND: begin
        en_reg_state_o = 1'b1;
        en_round_o     = 1'b1;
        en_xor_data_o  = (round_i == FIRST_PB);
        en_cipher_o    = (round_i == FIRST_PB);
        en_block_o     = last_round;
      end
      FIN_RND: begin
        en_reg_state_o     = 1'b1;
        en_round_o         = 1'b1;
        en_xor_data_o      = (round_i == FIRST_PA);
        en_cipher_o        = (round_i == FIRST_PA);
        en_xor_key_begin_o = (round_i == FIRST_PA);
        en_xor_key_end_o   = last_round;
        en_tag_o           = last_round;
      end
      default: ;
    endcase
  end

endmodule
